ram_stream_reader: RTL

Avalon-MM read initiator that drains a range of 32-bit words from the 256×32 single-port on-chip memory and presents them as a valid/ready stream, e.g. to a sample or pixel sink. It is the master end of the on-chip memory's slave port and assumes that port's fixed one-cycle read latency with no waitrequest. A 4-entry buffer and credit check sustain 1 word/clk under backpressure without losing in-flight read data.

---
 rtl/ram_stream_reader_pkg.sv | 17 +
 rtl/ram_stream_fifo.sv | 59 +++++
 rtl/ram_stream_reader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the ram_stream_reader block.
// Files importing this package: ram_stream_fifo.sv, ram_stream_reader.sv.
package ram_stream_reader_pkg;

   localparam int         DEPTH_DEF  = 4;      // default output buffer entries
   localparam int         ADDR_W_DEF = 8;      // default memory word-address width
   localparam int         DATA_W     = 32;     // memory / stream word width
   localparam logic [3:0] BE_ALL     = 4'hF;   // full-word byte enable

   // Transfer control states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/ram_stream_fifo.sv
// Show-ahead synchronous FIFO: head word is visible on head_data whenever
// head_valid is high; pop consumes it. flush empties the FIFO in one cycle
// and takes priority over a same-cycle push or pop.
module ram_stream_fifo
   import ram_stream_reader_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              flush,
   output logic [DATA_W-1:0] head_data,
   output logic              head_valid,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count_q;
   logic              do_pop;

   assign do_pop = pop && (count_q != '0);

   // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged
   always_ff @(posedge clk) begin
      // NOTE: registers use <= so every flop samples values from before the edge
      if (!reset_n || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Word storage
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; the pointers alone define which entries are valid
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head_data  = mem[rd_ptr];
   assign head_valid = (count_q != '0);
   assign count      = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Avalon-MM read initiator that streams a range of words from a one-cycle
// latency on-chip memory out through a valid/ready interface.
// Optional feature macro: RAM_STREAM_READER_LOOP_EN (continuous looping of the
// range until abort or reset; one-shot transfer when undefined).
module ram_stream_reader
   import ram_stream_reader_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_chipselect,
   output logic              avm_write,
   output logic [3:0]        avm_byteenable,
   input  logic [DATA_W-1:0] avm_readdata,
   output logic [DATA_W-1:0] st_data,
   output logic              st_valid,
   input  logic              st_ready
);

   localparam int LEN_W = ADDR_W + 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);

`ifdef RAM_STREAM_READER_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   state_e            state_q;
   state_e            state_d;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] index_q;
   logic [LEN_W-1:0]  length_q;
   logic [LEN_W-1:0]  remaining_q;
   logic              inflight_q;
   logic              zero_done_q;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    credits_used;
   logic              drained;
   logic              issue;
   logic              last_issue;
   logic              flush;
   logic              pop;

   // Buffer entries already spoken for: stored words plus the read still returning
   assign credits_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
   assign drained      = !inflight_q && (fifo_count == '0);
   assign pop          = st_valid && st_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; abort wins over every other transition
   always_comb begin
      // NOTE: default assignment first keeps this block free of latches
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start && (length != '0))          state_d = RUN;
         RUN:     if (abort)                            state_d = IDLE;
                  else if (last_issue && !LOOP_EN)      state_d = DRAIN;
         DRAIN:   if (abort || drained)                 state_d = IDLE;
         default:                                       state_d = IDLE;
      endcase
   end

   // Output decode: read issue under credit check, busy/done and buffer flush
   always_comb begin
      busy       = 1'b0;
      done       = zero_done_q;
      issue      = 1'b0;
      last_issue = 1'b0;
      flush      = 1'b0;
      case (state_q)
         RUN: begin
            busy       = 1'b1;
            flush      = abort;
            issue      = !abort && (remaining_q != '0) && (credits_used < CREDITS);
            last_issue = issue && (remaining_q == LEN_W'(1));
         end
         DRAIN: begin
            busy  = !drained;
            flush = abort;
            done  = drained && !abort;
         end
         default: ;
      endcase
   end

   // Transfer bookkeeping: latched range, read cursor and in-flight tracking
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         base_q      <= '0;
         index_q     <= '0;
         length_q    <= '0;
         remaining_q <= '0;
         inflight_q  <= 1'b0;
         zero_done_q <= 1'b0;
      end else begin
         inflight_q  <= issue;
         zero_done_q <= (state_q == IDLE) && start && (length == '0);
         if ((state_q == IDLE) && start) begin
            base_q      <= base_addr;
            length_q    <= length;
            index_q     <= '0;
            remaining_q <= length;
         end else if (issue) begin
            if (LOOP_EN && last_issue) begin
               index_q     <= '0;
               remaining_q <= length_q;
            end else begin
               index_q     <= index_q + ADDR_W'(1);
               remaining_q <= remaining_q - LEN_W'(1);
            end
         end
      end
   end

   ram_stream_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (inflight_q),
      .push_data  (avm_readdata),
      .pop        (pop),
      .flush      (flush),
      .head_data  (st_data),
      .head_valid (st_valid),
      .count      (fifo_count)
   );

   // Address wraps naturally at the memory size
   assign avm_address    = base_q + index_q;
   assign avm_chipselect = issue;
   assign avm_write      = 1'b0;
   assign avm_byteenable = BE_ALL;

endmodule
